mar_mem_ctrl: RTL

//  Parametrised successor of the LC-3b MAR path. Selects the next memory address

---
 rtl/mar_mem_pkg.sv | 16 +
 rtl/mar_src_mux.sv | 41 ++++
 rtl/mar_mem_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mar_mem_pkg.sv
// Shared constants for the MAR / memory-handshake block.
//   MAR_SEL_* : encodings of the 2-bit mar_sel control-store field
//   state_e   : handshake FSM states
package mar_mem_pkg;

  localparam logic [1:0] MAR_SEL_IR    = 2'd0;
  localparam logic [1:0] MAR_SEL_ADDER = 2'd1;
  localparam logic [1:0] MAR_SEL_INC   = 2'd2;
  localparam logic [1:0] MAR_SEL_HOLD  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mar_src_mux.sv
// Next-MAR source select (purely combinational).
//   mar_sel  in  2       source select (IR vector, adder, increment, hold)
//   ir_vec   in  VEC_W   low instruction bits used as a vector number
//   adder    in  ADDR_W  address adder result
//   mar      in  ADDR_W  current MAR
//   size_q   in  1       size of the last started access (1 = word)
//   mar_nxt  out ADDR_W  candidate MAR value
module mar_src_mux
  import mar_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int VEC_W     = 8,
  parameter int VEC_SHIFT = 1
) (
  input  logic [1:0]        mar_sel,
  input  logic [VEC_W-1:0]  ir_vec,
  input  logic [ADDR_W-1:0] adder,
  input  logic [ADDR_W-1:0] mar,
  input  logic              size_q,
  output logic [ADDR_W-1:0] mar_nxt
);

  logic [ADDR_W-1:0] vec_addr;
  logic [ADDR_W-1:0] inc_addr;

  // Zero-extend first, then shift, so bits pushed past ADDR_W are dropped.
  assign vec_addr = ADDR_W'(ir_vec) << VEC_SHIFT;

  // Step by the size of the previous access; wraps naturally at 2^ADDR_W.
  assign inc_addr = mar + (size_q ? ADDR_W'(2) : ADDR_W'(1));

  always_comb begin
    case (mar_sel)
      MAR_SEL_IR:    mar_nxt = vec_addr;
      MAR_SEL_ADDER: mar_nxt = adder;
      MAR_SEL_INC:   mar_nxt = inc_addr;
      default:       mar_nxt = mar;
    endcase
  end

endmodule

// File: rtl/mar_mem_ctrl.sv
// MAR register plus one-access-per-start memory handshake with alignment
// check and ready timeout.
//   clk, rst_n        clock / asynchronous active-low reset
//   ld_mar, mar_sel   load MAR from selected source (honoured in IDLE only)
//   ir_in, adder      MAR sources
//   mio_en            start an access at the current MAR
//   r_w, data_size    write / word flags, captured at start
//   mem_ready         memory completion
//   mar               MAR contents, also the memory address
//   mem_en, mem_we    memory strobe and write enable while BUSY
//   busy              FSM is in BUSY
//   done, unaligned, timed_out  registered one-cycle result pulses
module mar_mem_ctrl
  import mar_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int VEC_W     = 8,
  parameter int VEC_SHIFT = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_mar,
  input  logic [1:0]        mar_sel,
  input  logic [15:0]       ir_in,
  input  logic [ADDR_W-1:0] adder,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic              data_size,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mar,
  output logic              mem_en,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              unaligned,
  output logic              timed_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d, mar_nxt;
  logic              we_q, we_d;
  logic              size_q, size_d;
  logic              done_q, done_d;
  logic              unal_q, unal_d;
  logic              tout_q, tout_d;

  generate
    if (VEC_W < 16) begin : g_ir_spare
      logic unused_ir_hi;
      assign unused_ir_hi = ^ir_in[15:VEC_W];
    end
  endgenerate

  mar_src_mux #(
    .ADDR_W    (ADDR_W),
    .VEC_W     (VEC_W),
    .VEC_SHIFT (VEC_SHIFT)
  ) u_src_mux (
    .mar_sel (mar_sel),
    .ir_vec  (ir_in[VEC_W-1:0]),
    .adder   (adder),
    .mar     (mar_q),
    .size_q  (size_q),
    .mar_nxt (mar_nxt)
  );

  always_comb begin
    // NOTE: every signal gets a hold/default value up front so no path through
    // the case leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    we_d    = we_q;
    size_d  = size_q;
    done_d  = 1'b0;
    unal_d  = 1'b0;
    tout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A load in the same cycle as a start wins; the start is dropped.
        if (ld_mar) begin
          mar_d = mar_nxt;
        end else if (mio_en) begin
          if (data_size && mar_q[0]) begin
            unal_d = 1'b1;
          end else begin
            state_d = ST_BUSY;
            we_d    = r_w;
            size_d  = data_size;
            cnt_d   = '0;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ready is checked first so it beats a timeout on the final count.
        if (mem_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          tout_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 1'b1;
      done_q  <= 1'b0;
      unal_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      we_q    <= we_d;
      size_q  <= size_d;
      done_q  <= done_d;
      unal_q  <= unal_d;
      tout_q  <= tout_d;
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign mem_en    = busy;
  assign mem_we    = busy & we_q;
  assign mar       = mar_q;
  assign done      = done_q;
  assign unaligned = unal_q;
  assign timed_out = tout_q;

endmodule
